// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
//   Shared types and constants for the instruction fetch unit.
//   - fetch_state_t : fetch sequencer states (FILL, RUN, HOLD)
//   - INSTR_BYTES   : bytes per instruction word (PC increment)
//   - NOP_INSTR     : addi x0,x0,0, driven on if_instr when no word is valid
//   - if_bundle_t   : the word/PC/fault group presented to the IF/ID register
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FILL = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } if_bundle_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// fetch_perf_counters
//   Saturating fetch statistics, built only when FETCH_PERF_CNT_EN is defined.
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   asynchronous active-high reset, clears both counters
//     if_valid     in   fetch output carries a real instruction this cycle
//     stall        in   IF/ID hold request this cycle
//     perf_fetched out  cycles with if_valid=1 and stall=0 (saturating)
//     perf_bubbles out  cycles with if_valid=0 outside reset (saturating)
module fetch_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_valid,
  input  logic        stall,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (if_valid && !stall) perf_fetched <= sat_inc(perf_fetched);
      if (!if_valid)          perf_bubbles <= sat_inc(perf_bubbles);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch-side initiator for a synchronous, byte-addressable, big-endian
//   instruction memory with one cycle of read latency. Owns the PC, issues one
//   word address per cycle, pairs each returned word with its PC, absorbs
//   decode stalls in a hold buffer and squashes wrong-path words on redirect.
//   Optional macro: FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles.
//   Ports:
//     clk            in   system clock, rising edge
//     reset          in   asynchronous active-high reset
//     imem_addr      out  byte address to instruction memory (= pc_q)
//     imem_instr     in   memory word for last cycle's imem_addr
//     stall          in   IF/ID hold request
//     redirect_valid in   taken branch/jump from EX (wins over stall)
//     redirect_pc    in   redirect target
//     if_valid       out  if_instr/if_pc carry a real instruction
//     if_instr       out  fetched instruction
//     if_pc          out  address of if_instr
//     if_pc_plus4    out  if_pc + 4 (mod 2^32)
//     fetch_fault    out  out-of-range or misaligned-target fetch
//     perf_fetched   out  (FETCH_PERF_CNT_EN) delivered-instruction count
//     perf_bubbles   out  (FETCH_PERF_CNT_EN) invalid-output cycle count
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         fault_q, fault_d;
  logic         mis_q, mis_d;
  logic         advance;
  if_bundle_t   out_b;

  // Stage boundary: fetch request (pc_q) -> returned word (req_pc_q/fault_q)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FILL;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      hold_q   <= '0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
      fault_q  <= fault_d;
      mis_q    <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    hold_d      = hold_q;
    fault_d     = fault_q;
    mis_d       = mis_q;
    advance     = 1'b0;
    out_b.valid = 1'b0;
    out_b.instr = NOP_INSTR;
    out_b.pc    = req_pc_q;
    out_b.fault = 1'b0;

    unique case (state_q)
      FILL: begin
        advance = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        out_b.valid = 1'b1;
        out_b.instr = imem_instr;
        out_b.fault = fault_q;
        if (stall) begin
          // Capture the word now; memory keeps reading pc_q, which is the
          // address needed once the stall lifts.
          hold_d  = imem_instr;
          state_d = HOLD;
        end else begin
          advance = 1'b1;
        end
      end
      HOLD: begin
        out_b.valid = 1'b1;
        out_b.instr = hold_q;
        out_b.fault = fault_q;
        if (!stall) begin
          advance = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = FILL;
    endcase

    if (advance) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + INSTR_BYTES;
      // A misaligned redirect target only taints the first word fetched.
      fault_d  = (pc_q >= IMEM_LIMIT) || mis_q;
      mis_d    = 1'b0;
    end

    if (redirect_valid) begin
      out_b.valid = 1'b0;
      out_b.instr = NOP_INSTR;
      out_b.fault = 1'b0;
      pc_d        = {redirect_pc[31:2], 2'b00};
      hold_d      = '0;
      mis_d       = |redirect_pc[1:0];
      state_d     = FILL;
    end
  end

  assign imem_addr   = pc_q;
  assign if_valid    = out_b.valid;
  assign if_instr    = out_b.instr;
  assign if_pc       = out_b.pc;
  assign if_pc_plus4 = out_b.pc + INSTR_BYTES;
  assign fetch_fault = out_b.fault;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk          (clk),
    .reset        (reset),
    .if_valid     (out_b.valid),
    .stall        (stall),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_fault    (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  initial forever #5 clk = ~clk;

  // Memory: 256 bytes, big-endian words, one-cycle read latency.
  logic [7:0] mem [256];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b], mem[8'(b + 8'd1)], mem[8'(b + 8'd2)], mem[8'(b + 8'd3)]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[4] = 8'h00; mem[5] = 8'hF0; mem[6] = 8'h00; mem[7] = 8'h93;
    imem_instr = '0;
  end

  always @(posedge clk) imem_instr <= word_at(imem_addr);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: the sequence of PCs the decode side should see. A redirect or reset
  // leaves one further empty cycle, then the stream resumes at the target;
  // a stalled valid word is re-shown; otherwise the next PC is shown.
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_next;
  logic        m_mis;
  logic [31:0] m_fetched;
  logic [31:0] m_bubbles;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid   <= 1'b0;
      m_pc      <= '0;
      m_fault   <= 1'b0;
      m_next    <= 32'h0;
      m_mis     <= 1'b0;
      m_fetched <= '0;
      m_bubbles <= '0;
    end else begin
      if (m_valid && !redirect_valid && !stall) m_fetched <= m_fetched + 1;
      if (!(m_valid && !redirect_valid))        m_bubbles <= m_bubbles + 1;
      if (redirect_valid) begin
        m_valid <= 1'b0;
        m_next  <= redirect_pc & 32'hFFFF_FFFC;
        m_mis   <= (redirect_pc % 4) != 0;
      end else if (m_valid && stall) begin
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b1;
        m_pc    <= m_next;
        m_fault <= (m_next >= 64) || m_mis;
        m_mis   <= 1'b0;
        m_next  <= m_next + 4;
      end
    end
  end

  always @(negedge clk) begin
    logic ev;
    if (!reset) begin
      ev = m_valid && !redirect_valid;
      chk("m_valid", {31'b0, if_valid}, {31'b0, ev});
      if (ev) begin
        chk("m_pc", if_pc, m_pc);
        chk("m_instr", if_instr, word_at(m_pc));
        chk("m_pc_plus4", if_pc_plus4, m_pc + 4);
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      end
`ifdef FETCH_PERF_CNT_EN
      chk("m_perf_fetched", perf_fetched, m_fetched);
      chk("m_perf_bubbles", perf_bubbles, m_bubbles);
`endif
    end
  end

  task automatic tick(input logic s, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("fill_valid", {31'b0, if_valid}, 32'd0);

    tick(0, 0, 0);
    chk("c1_valid", {31'b0, if_valid}, 32'd1);
    chk("c1_pc", if_pc, 32'h0);
    chk("c1_instr", if_instr, 32'h0);

    // Stall for three cycles while pc 4 is presented.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h00F0_0093);
      chk("stall_plus4", if_pc_plus4, 32'h8);
    end
    tick(0, 0, 0);
    chk("release_pc", if_pc, 32'h4);
    tick(0, 0, 0);
    chk("next_pc", if_pc, 32'h8);
    chk("next_instr", if_instr, 32'h5253_5051);
    tick(0, 0, 0);
    chk("next2_pc", if_pc, 32'hC);

    // Redirect together with stall.
    tick(1, 1, 32'h18);
    chk("rd_r0_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 0, 0);
    chk("rd_r1_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 0, 0);
    chk("rd_r2_valid", {31'b0, if_valid}, 32'd1);
    chk("rd_r2_pc", if_pc, 32'h18);
    chk("rd_r2_instr", if_instr, 32'h4243_4041);
    chk("rd_r2_fault", {31'b0, fetch_fault}, 32'd0);

    // Misaligned redirect target.
    tick(0, 1, 32'h1A);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("mis_pc", if_pc, 32'h18);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    tick(0, 0, 0);
    chk("mis_next_fault", {31'b0, fetch_fault}, 32'd0);

    // Sequential fetch across the end of instruction memory.
    tick(0, 1, 32'h38);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("rng_38_pc", if_pc, 32'h38);
    tick(0, 0, 0);
    chk("rng_3c_fault", {31'b0, fetch_fault}, 32'd0);
    tick(0, 0, 0);
    chk("rng_40_pc", if_pc, 32'h40);
    chk("rng_40_fault", {31'b0, fetch_fault}, 32'd1);

    // Wrap of the 32-bit address space.
    tick(0, 1, 32'hFFFF_FFF8);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("wrap_f8_pc", if_pc, 32'hFFFF_FFF8);
    tick(0, 0, 0);
    chk("wrap_plus4", if_pc_plus4, 32'h0);
    tick(0, 0, 0);
    chk("wrap_0_pc", if_pc, 32'h0);
    chk("wrap_0_fault", {31'b0, fetch_fault}, 32'd0);

    // Redirect while holding, without stall.
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 32'h8);
    chk("hold_rd_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("hold_rd_pc", if_pc, 32'h8);
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("pre_rst_pc", if_pc, 32'hC);

    // Asynchronous reset in the middle of a hold.
    reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, if_valid}, 32'd0);
    chk("async_fault", {31'b0, fetch_fault}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("async_perf_fetched", perf_fetched, 32'd0);
    chk("async_perf_bubbles", perf_bubbles, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rr_fill_valid", {31'b0, if_valid}, 32'd0);
    tick(0, 0, 0);
    chk("rr_valid", {31'b0, if_valid}, 32'd1);
    chk("rr_pc", if_pc, 32'h0);
    repeat (4) tick(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
